// File: rtl/mem_arbiter_if.sv
// Handshake and memory-bus signals shared by mem_arbiter and its surroundings.
// The master modport is the arbiter's view; slave is the requesters-plus-memory view.
interface mem_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 if_req;
    logic [AddrWidth-1:0] if_addr;
    logic                 if_ready;
    logic                 if_rsp_valid;
    logic [DataWidth-1:0] if_rsp_data;

    logic                 d_req;
    logic                 d_we;
    logic [AddrWidth-1:0] d_addr;
    logic [DataWidth-1:0] d_wdata;
    logic                 d_ready;
    logic                 d_rsp_valid;
    logic [DataWidth-1:0] d_rsp_data;

    logic [AddrWidth-1:0] mem_addr;
    logic                 mem_read;
    logic                 mem_write;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rsp_valid, if_rsp_data,
        output d_ready, d_rsp_valid, d_rsp_data,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rsp_valid, if_rsp_data,
        input  d_ready, d_rsp_valid, d_rsp_data,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data has priority; a saturating wait counter lets a starved fetch win.
module mem_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 3
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master bus
);
    localparam logic [3:0] WaitLimit = 4'(MaxWait);

    logic [3:0]           wait_cnt;
    logic                 grant_i;
    logic                 grant_d;
    logic                 d_store;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] rd_word;

    always_comb begin
        grant_i = !rst && bus.if_req && (!bus.d_req || (wait_cnt >= WaitLimit));
        grant_d = !rst && bus.d_req && !grant_i;
        d_store = grant_d && bus.d_we;
    end

    assign bus.if_ready = grant_i;
    assign bus.d_ready  = grant_d;

    always_comb begin
        sel_addr      = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = '0;
        if (grant_i) begin
            sel_addr     = bus.if_addr;
            bus.mem_read = 1'b1;
        end else if (grant_d) begin
            sel_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.mem_read = 1'b1;
            end
        end
    end

    assign bus.mem_addr = sel_addr;
    // Only look at the memory's data lines when we actually enabled a read.
    assign rd_word = bus.mem_read ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_data  <= '0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rsp_data   <= '0;
        end else begin
            bus.if_rsp_valid <= grant_i;
            bus.d_rsp_valid  <= grant_d;
            if (grant_i) begin
                bus.if_rsp_data <= rd_word;
            end
            if (grant_d) begin
                bus.d_rsp_data <= d_store ? '0 : rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (grant_i || !bus.if_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts grants, bus drive and responses.
module tb_mem_arbiter;
    localparam int MaxWait = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    mem_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxWait(MaxWait)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment memory; a fixed junk pattern stands in for the undriven bus.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic        exp_if_v = 1'b0;
    logic        exp_d_v  = 1'b0;
    logic [31:0] last_if  = '0;
    logic [31:0] last_d   = '0;
    int          m_wait   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_rsp();
        logic [31:0] e;
        check_eq("if_rsp_valid", bus.if_rsp_valid, exp_if_v);
        if (exp_if_v) begin
            e = (if_q.size() > 0) ? if_q.pop_front() : 32'hFFFF_FFFF;
            last_if = e;
        end
        check_eq("if_rsp_data", bus.if_rsp_data, last_if);
        check_eq("d_rsp_valid", bus.d_rsp_valid, exp_d_v);
        if (exp_d_v) begin
            e = (d_q.size() > 0) ? d_q.pop_front() : 32'hFFFF_FFFF;
            last_d = e;
        end
        check_eq("d_rsp_data", bus.d_rsp_data, last_d);
    endtask

    // Called just after a posedge: drives one cycle of requests and checks it at the negedge.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic gi, gd;
        bus.if_req = ir; bus.if_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        gi = ir && (!dr || m_wait >= MaxWait);
        gd = dr && !gi;
        @(negedge clk);
        check_rsp();
        check_eq("if_ready", bus.if_ready, gi);
        check_eq("d_ready", bus.d_ready, gd);
        check_eq("mem_read", bus.mem_read, gi || (gd && !dw));
        check_eq("mem_write", bus.mem_write, gd && dw);
        check_eq("mem_addr", bus.mem_addr, gi ? ia : (gd ? da : 32'h0));
        check_eq("mem_wdata", bus.mem_wdata, (gd && dw) ? dd : 32'h0);
        if (gi) if_q.push_back(ref_mem[ia[9:2]]);
        if (gd) d_q.push_back(dw ? 32'h0 : ref_mem[da[9:2]]);
        if (gd && dw) ref_mem[da[9:2]] = dd;
        exp_if_v = gi;
        exp_d_v  = gd;
        if (gi || !ir) m_wait = 0;
        else if (m_wait < 15) m_wait++;
        @(posedge clk); #1;
        check_eq("wait_cnt", 32'(dut.wait_cnt), m_wait);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic flush_model();
        if_q.delete(); d_q.delete();
        exp_if_v = 1'b0; exp_d_v = 1'b0;
        last_if = '0; last_d = '0; m_wait = 0;
    endtask

    task automatic check_reset_state();
        check_eq("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
        check_eq("rst_d_rsp_valid", bus.d_rsp_valid, 1'b0);
        check_eq("rst_if_rsp_data", bus.if_rsp_data, 32'h0);
        check_eq("rst_d_rsp_data", bus.d_rsp_data, 32'h0);
        check_eq("rst_mem_read", bus.mem_read, 1'b0);
        check_eq("rst_mem_write", bus.mem_write, 1'b0);
        check_eq("rst_if_ready", bus.if_ready, 1'b0);
        check_eq("rst_d_ready", bus.d_ready, 1'b0);
        check_eq("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset pulse in the middle of a low clock phase.
        #3 rst = 1'b1;
        #1 check_reset_state();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        flush_model();

        idle(2);
        // Lone fetch, then the same word through an unaligned address.
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        // Store then load of the same word, then a fetch of it.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D);
        step(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        // Sustained contention: fetch should win every fourth cycle.
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h10, 1'b1, 1'b0, 32'(8 * i), 32'h0);
        idle(1);
        // Randomised traffic.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)), $urandom);
        idle(1);

        // Reset lands between the grant and the posedge that would deliver it.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10; bus.if_req = 1'b1; bus.if_addr = 32'h20;
        @(negedge clk);
        check_eq("pre_rst_d_ready", bus.d_ready, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_state();
        flush_model();
        @(posedge clk); #1;
        check_reset_state();
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        idle(2);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word-addressed memory between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Sits between the core's fetch and load/store stages and the memory block.
- Grants at most one access per cycle and captures read data into a registered response.
- Data port has priority; a wait counter prevents fetch starvation.

Parameters:
- AddrWidth, 32, byte address width; memory word index is addr[MemAddrWidth+1:2], addr[1:0] ignored.
- DataWidth, 32, word width.
- MaxWait, 3, consecutive denied fetch cycles after which fetch wins the next arbitration (range 1..15).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request valid; held with if_addr stable until if_ready.
- if_addr  in  AddrWidth  fetch byte address.
- if_ready  out  1  fetch request accepted this cycle (combinational grant).
- if_rsp_valid  out  1  fetch response valid (registered).
- if_rsp_data  out  DataWidth  fetch read data.
- d_req  in  1  data request valid; held with fields stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AddrWidth  data byte address.
- d_wdata  in  DataWidth  store data.
- d_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  data response valid: load data or store acknowledge.
- d_rsp_data  out  DataWidth  load data; 0 for store acknowledge.
- mem_addr  out  AddrWidth  memory address; 0 when idle.
- mem_read  out  1  memory read enable (ENABLE/DISABLE encoding).
- mem_write  out  1  memory write enable.
- mem_wdata  out  DataWidth  memory write data.
- mem_rdata  in  DataWidth  memory read data; combinational in the same cycle as mem_read, Z when mem_read is disabled.

Behaviour:
- Arbitration is combinational each cycle from if_req, d_req and wait_cnt.
- grant_i when if_req && (!d_req || wait_cnt >= MaxWait).
- grant_d when d_req && !grant_i.
- grant_i and grant_d are mutually exclusive.
- if_ready = grant_i; d_ready = grant_d.
- Bus drive:
  - On grant_i: mem_addr = if_addr, mem_read = 1, mem_write = 0.
  - On grant_d load: mem_addr = d_addr, mem_read = 1, mem_write = 0.
  - On grant_d store: mem_addr = d_addr, mem_read = 0, mem_write = 1, mem_wdata = d_wdata.
  - With no grant, all mem_* outputs are 0; mem_read is never asserted without a grant.
  - mem_rdata is sampled only when the arbiter drove mem_read high that cycle.
- Response latency is exactly 1 cycle:
  - At the posedge ending a grant cycle, the granted port's rsp_valid is set for one cycle.
  - if_rsp_data / d_rsp_data take mem_rdata (load) or 0 (store).
  - A store is written into memory on that same posedge.
  - rsp_valid is a single-cycle pulse. A port with no grant in the previous cycle shows rsp_valid = 0.
  - rsp_data holds its last value when rsp_valid = 0.
  - No response backpressure: requesters must consume a response in its valid cycle.
- Throughput: one access per cycle; back-to-back grants to the same port are allowed.
- wait_cnt (4-bit, saturating at 15):
  - Increments when if_req && !grant_i.
  - Clears when grant_i or !if_req.
- Read-after-write: a data store granted in cycle N followed by a fetch or load of the same address in cycle N+1 returns the stored value.
- Reset (async, any time):
  - if_rsp_valid = d_rsp_valid = 0, if_rsp_data = d_rsp_data = 0, wait_cnt = 0.
  - Any response pending for the cycle of reset is dropped and never delivered.
  - While rst is high, grants are forced to 0, so if_ready = d_ready = 0 and mem_read = mem_write = 0.

Test Plan:
- Reset then idle: rst pulse mid-cycle, no requests -> all rsp_valid 0, mem_read/mem_write 0, wait_cnt 0 immediately on rst rise.
- Lone fetch: if_req, if_addr=0x10 with mem word 4 = 0xDEADBEEF -> if_ready same cycle, next cycle if_rsp_valid=1 and if_rsp_data=0xDEADBEEF.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x12345678, then load 0x20 -> store ack d_rsp_data=0, next-cycle load response d_rsp_data=0x12345678.
- Contention with MaxWait=3: if_req and d_req held continuously -> d granted cycles 0-2, fetch granted cycle 3, wait_cnt back to 0, then d granted again.
- Reset mid-operation: load granted, rst asserted before the next posedge -> d_rsp_valid never pulses, outputs at reset values.
- Address LSBs: fetch 0x13 -> same data as 0x10.
